// File: rtl/operand_load_sched.sv
// ---------------------------------------------------------------------------
// operand_load_sched
//
// Purpose:
//   Loads one operand frame from the UART byte stream into two BRAMs and then
//   streams both BRAMs to the Booth systolic array.
//   - Bytes 0..DEPTH-1 of a frame are written to BRAM A.
//   - Bytes DEPTH..2*DEPTH-1 are written to BRAM B.
//   - Both BRAMs are then read out in lockstep, one address per cycle.
//   - The block waits for the array's done pulse before it accepts the next frame.
//
// Optional feature (macro FRAME_CHECKSUM_EN):
//   - After the payload, one extra checksum byte is taken. It is the modulo-2**DATA_W
//     sum of all 2*DEPTH payload bytes.
//   - On a match the frame is streamed.
//   - On a mismatch o_err pulses for one cycle and the frame is discarded.
//   - Without the macro there is no CHECK state and no o_err port.
//
// Ports:
//   clk          single clock
//   reset        asynchronous, active-low reset
//   i_rx_data    received byte
//   i_rx_valid   1-cycle strobe qualifying i_rx_data
//   o_wea/o_web  BRAM A / BRAM B write enables (never both high)
//   o_waddr      shared write address
//   o_wdata      shared write data
//   o_raddr      shared read address
//   o_sa_valid   BRAM outputs hold the operand pair this cycle
//   o_sa_last    final pair (index DEPTH-1), only together with o_sa_valid
//   i_sa_done    1-cycle completion pulse from the array
//   o_busy       high in STREAM and WAIT_DONE
//   o_ovf        sticky: a byte arrived while busy and was dropped
//   o_err        (FRAME_CHECKSUM_EN only) 1-cycle checksum-mismatch pulse
//   o_dbg_state  current FSM state, for observation only
//
// Parameters:
//   DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W.
//   RD_LATENCY must be in the range 1..3.
// ---------------------------------------------------------------------------
module operand_load_sched #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_wea,
    output logic              o_web,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [ADDR_W-1:0] o_raddr,
    output logic              o_sa_valid,
    output logic              o_sa_last,
    input  logic              i_sa_done,
    output logic              o_busy,
    output logic              o_ovf,
`ifdef FRAME_CHECKSUM_EN
    output logic              o_err,
`endif
    output logic [2:0]        o_dbg_state
);

    // Handshake semantics:
    //   - i_rx_valid is a fire-and-forget strobe with no ready.
    //   - A byte is taken whenever i_rx_valid is high in a loading (or check) state.
    //   - In STREAM/WAIT_DONE the byte is lost and o_ovf records that.
    //   - o_sa_valid is likewise a strobe; the array is assumed always able to accept.

    localparam logic [2:0] S_LOAD_A    = 3'd0;
    localparam logic [2:0] S_LOAD_B    = 3'd1;
    localparam logic [2:0] S_STREAM    = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
`ifdef FRAME_CHECKSUM_EN
    localparam logic [2:0] S_CHECK     = 3'd4;
`endif

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [ADDR_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]     r_raddr;
    logic                  r_wea;
    logic                  r_web;
    logic [ADDR_W-1:0]     r_waddr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_ovf;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic [RD_LATENCY-1:0] r_lpipe;

    logic w_cnt_last;
    logic w_raddr_last;
    logic w_accept_a;
    logic w_accept_b;
    logic w_issue;
    logic w_drop;
    logic w_done;
    logic w_busy;

`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              r_err;
    logic              w_check_strobe;
    logic              w_check_bad;
`endif

    assign w_cnt_last   = (r_cnt == LAST);
    assign w_raddr_last = (r_raddr == LAST);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD_A: begin
                if (i_rx_valid && w_cnt_last) begin
                    w_next = S_LOAD_B;
                end
            end

            S_LOAD_B: begin
                if (i_rx_valid && w_cnt_last) begin
`ifdef FRAME_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_STREAM;
`endif
                end
            end

`ifdef FRAME_CHECKSUM_EN
            S_CHECK: begin
                if (w_check_strobe) begin
                    w_next = w_check_bad ? S_LOAD_A : S_STREAM;
                end
            end
`endif

            S_STREAM: begin
                if (w_raddr_last) begin
                    w_next = S_WAIT_DONE;
                end
            end

            // The done pulse is honoured even while valids are still draining.
            S_WAIT_DONE: begin
                if (w_done) begin
                    w_next = S_LOAD_A;
                end
            end

            default: w_next = S_LOAD_A;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: output / strobe decode
    // ---------------------------------------------------------------
    always_comb begin
        w_accept_a = 1'b0;
        w_accept_b = 1'b0;
        w_issue    = 1'b0;
        w_drop     = 1'b0;
        w_done     = 1'b0;
        w_busy     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        w_check_strobe = 1'b0;
        w_check_bad    = 1'b0;
`endif
        case (r_state)
            S_LOAD_A: begin
                w_accept_a = i_rx_valid;
            end

            S_LOAD_B: begin
                w_accept_b = i_rx_valid;
            end

`ifdef FRAME_CHECKSUM_EN
            S_CHECK: begin
                w_check_strobe = i_rx_valid;
                w_check_bad    = i_rx_valid && (i_rx_data != r_sum);
            end
`endif

            S_STREAM: begin
                w_issue = 1'b1;
                w_busy  = 1'b1;
                w_drop  = i_rx_valid;
            end

            S_WAIT_DONE: begin
                w_busy = 1'b1;
                w_drop = i_rx_valid;
                w_done = i_sa_done;
            end

            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_raddr <= '0;
            r_wea   <= 1'b0;
            r_web   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_ovf   <= 1'b0;
            r_vpipe <= '0;
            r_lpipe <= '0;
        end else begin
            // Write path: one registered cycle behind the accepted strobe.
            r_wea <= w_accept_a;
            r_web <= w_accept_b;
            if (w_accept_a || w_accept_b) begin
                r_waddr <= r_cnt;
                r_wdata <= i_rx_data;
                r_cnt   <= w_cnt_last ? '0 : r_cnt + 1'b1;
            end

            // Read address:
            //   - Steps through the BRAM during STREAM.
            //   - Parks on the last entry in WAIT_DONE.
            //   - Returns to 0 on done.
            if (w_issue) begin
                if (!w_raddr_last) begin
                    r_raddr <= r_raddr + 1'b1;
                end
            end else if (w_done) begin
                r_raddr <= '0;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end

            // Valid/last travel alongside the BRAM read latency.
            // They keep shifting after STREAM ends, so the pipeline drains naturally.
            r_vpipe[0] <= w_issue;
            r_lpipe[0] <= w_issue && w_raddr_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_lpipe[i] <= r_lpipe[i-1];
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Running payload sum.
    // Every frame ends with a check byte, so it is cleared there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept_a || w_accept_b) begin
                r_sum <= r_sum + i_rx_data;
            end else if (w_check_strobe) begin
                r_sum <= '0;
            end
            r_err <= w_check_bad;
        end
    end

    assign o_err = r_err;
`endif

    assign o_wea       = r_wea;
    assign o_web       = r_web;
    assign o_waddr     = r_waddr;
    assign o_wdata     = r_wdata;
    assign o_raddr     = r_raddr;
    assign o_sa_valid  = r_vpipe[RD_LATENCY-1];
    assign o_sa_last   = r_lpipe[RD_LATENCY-1];
    assign o_busy      = w_busy;
    assign o_ovf       = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_operand_load_sched.sv
`timescale 1ns/1ps
// Directed bench for operand_load_sched.
// A small BRAM model sits on the write/read ports.
// Scoreboard queues hold:
//   - the expected write sequence (with the cycle it must appear in);
//   - the expected operand pairs of each stream.
module tb_operand_load_sched;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 3;
    localparam int WR_W   = 1 + ADDR_W + DATA_W + 32;
    localparam int ST_W   = 1 + 2 * DATA_W;

    localparam logic [2:0] ST_LOAD_A    = 3'd0;
    localparam logic [2:0] ST_STREAM    = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] i_rx_data;
    logic              i_rx_valid;
    logic              i_sa_done;
    logic              o_wea;
    logic              o_web;
    logic [ADDR_W-1:0] o_waddr;
    logic [DATA_W-1:0] o_wdata;
    logic [ADDR_W-1:0] o_raddr;
    logic              o_sa_valid;
    logic              o_sa_last;
    logic              o_busy;
    logic              o_ovf;
    logic [2:0]        o_dbg_state;
`ifdef FRAME_CHECKSUM_EN
    logic              o_err;
`endif

    operand_load_sched #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .RD_LATENCY(RD_LAT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_wea      (o_wea),
        .o_web      (o_web),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_raddr    (o_raddr),
        .o_sa_valid (o_sa_valid),
        .o_sa_last  (o_sa_last),
        .i_sa_done  (i_sa_done),
        .o_busy     (o_busy),
        .o_ovf      (o_ovf),
`ifdef FRAME_CHECKSUM_EN
        .o_err      (o_err),
`endif
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [WR_W-1:0] exp_q[$];   // {is_b, addr, data, due_cycle}
    logic [ST_W-1:0] st_q[$];    // {last, a, b}

    logic [DATA_W-1:0] fb[2*DEPTH];
    logic [DATA_W-1:0] pa[DEPTH];
    logic [DATA_W-1:0] pb[DEPTH];
    logic [ADDR_W-1:0] m_cnt;
    logic              m_is_b;

    // ---------------- BRAM model ----------------
    logic [DATA_W-1:0] mem_a[DEPTH];
    logic [DATA_W-1:0] mem_b[DEPTH];
    logic [ADDR_W-1:0] apipe[RD_LAT];
    logic [DATA_W-1:0] dout_a;
    logic [DATA_W-1:0] dout_b;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_wea) mem_a[o_waddr] <= o_wdata;
        if (o_web) mem_b[o_waddr] <= o_wdata;
        apipe[0] <= o_raddr;
        for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
    end

    assign dout_a = mem_a[apipe[RD_LAT-1]];
    assign dout_b = mem_b[apipe[RD_LAT-1]];

    // ---------------- check helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_true(input string tag, input logic cond);
        checks++;
        assert (cond === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=1", tag, cond);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [WR_W-1:0] we;
        logic [ST_W-1:0] se;
        if (reset) begin
            if (o_wea || o_web) begin
                chk("wr_onehot", 64'(o_wea && o_web), 64'd0);
                chk_true("wr_expected", exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    we = exp_q.pop_front();
                    chk("wr_sel_addr_data", 64'({o_web, o_waddr, o_wdata}), 64'(we[WR_W-1:32]));
                    chk("wr_cycle", 64'(cyc), 64'(we[31:0]));
                end
            end
            if (o_sa_last) chk_true("last_qualified", o_sa_valid);
            if (o_sa_valid) begin
                chk_true("pair_expected", st_q.size() != 0);
                if (st_q.size() != 0) begin
                    se = st_q.pop_front();
                    chk("pair_last_a_b", 64'({o_sa_last, dout_a, dout_b}), 64'(se));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end on a falling edge.
    task automatic rx(input logic [DATA_W-1:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic done_pulse();
        i_sa_done = 1'b1;
        @(negedge clk);
        i_sa_done = 1'b0;
    endtask

    task automatic load_byte(input logic [DATA_W-1:0] b);
        exp_q.push_back({m_is_b, m_cnt, b, 32'(cyc + 1)});
        if (m_is_b) pb[m_cnt] = b;
        else        pa[m_cnt] = b;
        rx(b);
        if (m_cnt == ADDR_W'(DEPTH - 1)) begin
            m_cnt  = '0;
            m_is_b = ~m_is_b;
        end else begin
            m_cnt = m_cnt + 1'b1;
        end
    endtask

    // Sends the 2*DEPTH bytes of fb.
    // done_at_byte >= 0 pulses i_sa_done before that byte.
    task automatic load_frame(input logic good_ck, input int done_at_byte);
        logic [DATA_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (i == done_at_byte) begin
                done_pulse();
                chk("done_ignored_load", 64'(o_dbg_state), 64'(ST_LOAD_A));
            end
            sum = sum + fb[i];
            load_byte(fb[i]);
        end
        if (good_ck) begin
            for (int i = 0; i < DEPTH; i++) st_q.push_back({(i == DEPTH - 1), pa[i], pb[i]});
        end
`ifdef FRAME_CHECKSUM_EN
        rx(good_ck ? sum : DATA_W'(sum + 1'b1));
`endif
    endtask

    // Called on the first STREAM cycle.
    // Checks the address walk, the valid window, busy and state.
    task automatic stream_check(input int done_at);
        logic              honoured;
        logic [ADDR_W-1:0] ea;
        logic [2:0]        es;
        logic              ev;
        honoured = (done_at > DEPTH);
        for (int k = 1; k <= DEPTH + RD_LAT + 1; k++) begin
            if (k <= DEPTH) begin
                ea = ADDR_W'(k - 1);
                es = ST_STREAM;
            end else if (honoured && k > done_at) begin
                ea = '0;
                es = ST_LOAD_A;
            end else begin
                ea = ADDR_W'(DEPTH - 1);
                es = ST_WAIT_DONE;
            end
            ev = (k > RD_LAT) && (k <= DEPTH + RD_LAT);
            chk("st_raddr", 64'(o_raddr), 64'(ea));
            chk("st_valid", 64'(o_sa_valid), 64'(ev));
            chk("st_busy",  64'(o_busy), 64'(es != ST_LOAD_A));
            chk("st_state", 64'(o_dbg_state), 64'(es));
            i_sa_done = (k == done_at);
            @(negedge clk);
        end
        i_sa_done = 1'b0;
        chk("st_pairs_left", 64'(st_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_wea",    64'(o_wea), 64'd0);
        chk("rst_web",    64'(o_web), 64'd0);
        chk("rst_waddr",  64'(o_waddr), 64'd0);
        chk("rst_wdata",  64'(o_wdata), 64'd0);
        chk("rst_raddr",  64'(o_raddr), 64'd0);
        chk("rst_valid",  64'(o_sa_valid), 64'd0);
        chk("rst_last",   64'(o_sa_last), 64'd0);
        chk("rst_busy",   64'(o_busy), 64'd0);
        chk("rst_ovf",    64'(o_ovf), 64'd0);
        chk("rst_state",  64'(o_dbg_state), 64'(ST_LOAD_A));
`ifdef FRAME_CHECKSUM_EN
        chk("rst_err",    64'(o_err), 64'd0);
`endif
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        i_rx_data  = '0;
        i_rx_valid = 1'b0;
        i_sa_done  = 1'b0;
        m_cnt      = '0;
        m_is_b     = 1'b0;

        // Reset state
        idle(3);
        check_reset_outputs();
        reset = 1'b1;
        idle(2);

        // Frame 1: bytes 0x01..0x20.
        // Expect A = 0x01..0x10 and B = 0x11..0x20.
        for (int i = 0; i < 2 * DEPTH; i++) fb[i] = DATA_W'(i + 1);
        load_frame(1'b1, -1);
        stream_check(0);

        // Byte dropped in WAIT_DONE, then done returns to LOAD_A
        rx(8'h55);
        chk("drop_ovf_set", 64'(o_ovf), 64'd1);
        chk("drop_state",   64'(o_dbg_state), 64'(ST_WAIT_DONE));
        done_pulse();
        chk("done_state", 64'(o_dbg_state), 64'(ST_LOAD_A));
        chk("done_raddr", 64'(o_raddr), 64'd0);
        chk("done_busy",  64'(o_busy), 64'd0);

        // Frame 2:
        //   - random payload;
        //   - done ignored in LOAD_A (mid-frame) and in STREAM.
        for (int i = 0; i < 2 * DEPTH; i++) fb[i] = DATA_W'($urandom_range(0, 255));
        load_frame(1'b1, 5);
        stream_check(5);
        chk("ovf_sticky", 64'(o_ovf), 64'd1);

        // Byte and done in the same WAIT_DONE cycle: transition taken, byte dropped
        i_rx_data  = 8'h77;
        i_rx_valid = 1'b1;
        i_sa_done  = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        i_sa_done  = 1'b0;
        chk("simul_state", 64'(o_dbg_state), 64'(ST_LOAD_A));
        chk("simul_ovf",   64'(o_ovf), 64'd1);

        // Frame 3: done the cycle after the last address; the pipeline still drains
        for (int i = 0; i < 2 * DEPTH; i++) fb[i] = DATA_W'(i * 7 + 3);
        load_frame(1'b1, -1);
        stream_check(DEPTH + 1);

        // Reset after 20 bytes, then a fresh frame starts A at address 0
        for (int i = 0; i < 2 * DEPTH; i++) fb[i] = DATA_W'($urandom_range(0, 255));
        for (int i = 0; i < 20; i++) load_byte(fb[i]);
        idle(1);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        chk("rst_wr_pending", 64'(exp_q.size()), 64'd0);
        idle(2);
        reset  = 1'b1;
        m_cnt  = '0;
        m_is_b = 1'b0;
        idle(1);
        for (int i = 0; i < 2 * DEPTH; i++) fb[i] = DATA_W'($urandom_range(0, 255));
        load_frame(1'b1, -1);
        stream_check(0);
        done_pulse();
        chk("frame4_state", 64'(o_dbg_state), 64'(ST_LOAD_A));

`ifdef FRAME_CHECKSUM_EN
        // Good checksum (32 x 0x01 -> 0x20) streams
        for (int i = 0; i < 2 * DEPTH; i++) fb[i] = 8'h01;
        load_frame(1'b1, -1);
        stream_check(0);
        done_pulse();

        // Bad checksum (0x21):
        //   - one-cycle o_err;
        //   - no stream;
        //   - back in LOAD_A.
        load_frame(1'b0, -1);
        chk("ck_err_pulse", 64'(o_err), 64'd1);
        chk("ck_err_state", 64'(o_dbg_state), 64'(ST_LOAD_A));
        idle(1);
        chk("ck_err_clear", 64'(o_err), 64'd0);
        for (int k = 0; k < DEPTH + RD_LAT; k++) begin
            chk("ck_no_valid", 64'(o_sa_valid), 64'd0);
            chk("ck_not_busy", 64'(o_busy), 64'd0);
            @(negedge clk);
        end
        chk("ck_wr_pending", 64'(exp_q.size()), 64'd0);
`endif

        idle(3);
        chk("final_wr_q_empty", 64'(exp_q.size()), 64'd0);
        chk("final_st_q_empty", 64'(st_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
